// File: rtl/sbox_share_scheduler_pkg.sv
// Shared types for the masked S-box scheduler: owner and FSM encodings
// plus the in-flight tag record carried alongside each issued byte.
package sbox_sched_pkg;

    localparam int TAG_W = 3;

    typedef enum logic {
        OWN_S = 1'b0,
        OWN_K = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_S = 2'd1,
        GRANT_K = 2'd2
    } state_t;

    typedef struct packed {
        logic   v;
        owner_t own;
        logic   last;
    } tag_t;

endpackage

// File: rtl/sbox_share_scheduler_if.sv
// Requester, PRNG and S-box signals of the scheduler in one bundle.
// The scheduler uses the slave modport; its environment uses master.
interface sbox_share_scheduler_if #(
    parameter int NSH = 4
);
    localparam int SW = 8 * NSH;

    logic          s_valid;
    logic          s_last;
    logic [SW-1:0] s_sh;
    logic          s_ready;
    logic          k_valid;
    logic          k_last;
    logic [SW-1:0] k_sh;
    logic          k_ready;
    logic          rnd_valid;
    logic          rnd_take;
    logic [SW-1:0] sb_in;
    logic [SW-1:0] sb_out;
    logic          s_res_valid;
    logic          s_res_last;
    logic [SW-1:0] s_res_sh;
    logic          k_res_valid;
    logic          k_res_last;
    logic [SW-1:0] k_res_sh;
    logic          busy;

    modport slave (
        input  s_valid, s_last, s_sh,
        input  k_valid, k_last, k_sh,
        input  rnd_valid, sb_out,
        output s_ready, k_ready, rnd_take, sb_in,
        output s_res_valid, s_res_last, s_res_sh,
        output k_res_valid, k_res_last, k_res_sh,
        output busy
    );

    modport master (
        output s_valid, s_last, s_sh,
        output k_valid, k_last, k_sh,
        output rnd_valid, sb_out,
        input  s_ready, k_ready, rnd_take, sb_in,
        input  s_res_valid, s_res_last, s_res_sh,
        input  k_res_valid, k_res_last, k_res_sh,
        input  busy
    );

endinterface

// File: rtl/sbox_share_scheduler_tag_pipe.sv
// LAT-deep shift register of {v, owner, last} tags that mirrors the
// S-box pipeline; synchronous clear drops everything in flight.
module sbox_tag_pipe
    import sbox_sched_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic clr,
    input  tag_t in_tag,
    output tag_t out_tag,
    output logic any_v
);

    tag_t pipe_q [LAT];
    tag_t pipe_d [LAT];

    always_comb begin
        pipe_d[0] = in_tag;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        any_v = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_v = any_v | pipe_q[i].v;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign out_tag = pipe_q[LAT-1];

endmodule

// File: rtl/sbox_share_scheduler.sv
// Shares one pipelined masked S-box between state and key requesters.
// Build option SBOX_IDLE_ZERO_EN: drive zeros into the S-box when idle.
module sbox_share_scheduler
    import sbox_sched_pkg::*;
#(
    parameter int LAT = 2,
    parameter int NSH = 4,
    parameter int RW  = 28
) (
    input logic                   CLK,
    input logic                   RST,
    sbox_share_scheduler_if.slave io
);

    localparam int SW = 8 * NSH;

    if (LAT < 1 || NSH < 1 || RW < 1) begin : g_bad_param
        $error("sbox_share_scheduler: LAT, NSH, RW must be positive");
    end

    state_t        state_q, state_d;
    owner_t        pref_q, pref_d;
    logic          issue;
    logic          iss_last;
    owner_t        iss_own;
    logic [SW-1:0] iss_sh;
    tag_t          tag_in;
    tag_t          tag_out;
    logic          any_v;
    logic          res_s;
    logic          res_k;

    // Only a locked grant may issue; reset suppresses any handshake.
    always_comb begin
        issue    = 1'b0;
        iss_last = 1'b0;
        iss_own  = OWN_S;
        iss_sh   = io.s_sh;
        case (state_q)
            GRANT_S: begin
                issue    = io.s_valid && io.rnd_valid && !RST;
                iss_last = io.s_last;
            end
            GRANT_K: begin
                issue    = io.k_valid && io.rnd_valid && !RST;
                iss_last = io.k_last;
                iss_own  = OWN_K;
                iss_sh   = io.k_sh;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pref_d  = pref_q;
        case (state_q)
            IDLE: begin
                if (io.s_valid && io.k_valid) begin
                    state_d = (pref_q == OWN_K) ? GRANT_K : GRANT_S;
                end else if (io.s_valid) begin
                    state_d = GRANT_S;
                end else if (io.k_valid) begin
                    state_d = GRANT_K;
                end
            end
            GRANT_S, GRANT_K: begin
                if (issue && iss_last) begin
                    state_d = IDLE;
                    pref_d  = (pref_q == OWN_K) ? OWN_S : OWN_K;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pref_q  <= OWN_K;
        end else begin
            state_q <= state_d;
            pref_q  <= pref_d;
        end
    end

`ifdef SBOX_IDLE_ZERO_EN
    assign io.sb_in = issue ? iss_sh : '0;
`else
    logic [SW-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = issue ? iss_sh : hold_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign io.sb_in = hold_d;
`endif

    assign io.s_ready  = issue && (iss_own == OWN_S);
    assign io.k_ready  = issue && (iss_own == OWN_K);
    assign io.rnd_take = issue;

    assign tag_in = '{
        v:    issue,
        own:  iss_own,
        last: issue && iss_last
    };

    sbox_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk     (CLK),
        .clr     (RST),
        .in_tag  (tag_in),
        .out_tag (tag_out),
        .any_v   (any_v)
    );

    // Results are never produced while reset is held, even from old tags.
    assign res_s = tag_out.v && (tag_out.own == OWN_S) && !RST;
    assign res_k = tag_out.v && (tag_out.own == OWN_K) && !RST;

    assign io.s_res_valid = res_s;
    assign io.s_res_last  = res_s && tag_out.last;
    assign io.s_res_sh    = res_s ? io.sb_out : '0;
    assign io.k_res_valid = res_k;
    assign io.k_res_last  = res_k && tag_out.last;
    assign io.k_res_sh    = res_k ? io.sb_out : '0;

    assign io.busy = (state_q != IDLE) || any_v;

endmodule

// File: doc/sbox_share_scheduler.md
Name: sbox_share_scheduler

Overview:
- Shares one pipelined 4-share masked S-box between two requesters: the state path (SubBytes, 16 bytes/round) and the key schedule (SubWord, 4 bytes/round).
- Arbitrates per burst and issues at most one byte per cycle, gated on fresh randomness.
- Tracks in-flight bytes through a tag pipeline and routes each result back to its owner.
- Sits between the round controller and the S-box instance in the masked AES core.

Parameters:
- LAT, 2, S-box latency in cycles from sb_in sampled to sb_out valid (two register stages).
- NSH, 4, number of Boolean shares per byte.
- RW, 28, randomness bits consumed per S-box issue.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- s_valid  in  1  state requester has a byte.
- s_last  in  1  final byte of the state burst.
- s_sh  in  8*NSH  state byte shares, share i at [8i+7:8i].
- s_ready  out  1  state byte accepted this cycle.
- k_valid, k_last, k_sh, k_ready  same as s_*, key requester.
- rnd_valid  in  1  PRNG has RW fresh bits available.
- rnd_take  out  1  consume RW bits this cycle (equals issue).
- sb_in  out  8*NSH  shares to the S-box.
- sb_out  in  8*NSH  shares from the S-box.
- s_res_valid  out  1  state result valid (1-cycle pulse).
- s_res_last  out  1  result corresponds to s_last.
- s_res_sh  out  8*NSH  result shares.
- k_res_valid, k_res_last, k_res_sh  same as s_res_*, key requester.
- busy  out  1  a burst is granted or any byte is in flight.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, tag pipeline cleared, rr_pref = KEY.
- FSM states:
  - IDLE: grant chosen when any *_valid is high. If both are high, grant goes to rr_pref, and rr_pref toggles at each burst end.
  - GRANT_S / GRANT_K: grant is locked to that requester until its *_last byte is issued, then the FSM returns to IDLE.
  - A byte issued together with *_last ends the burst in the same cycle. The next burst can begin on the following cycle, never the same cycle.
- Issue rule: issue = granted requester's *_valid && rnd_valid.
  - On issue: the *_ready of that requester = 1, rnd_take = 1, and sb_in = its *_sh, combinational in the same cycle.
  - The non-granted requester always sees *_ready = 0.
  - A requester with *_valid high and rnd_valid low stalls. No byte is issued, and the tag entry is invalid.
- Tag pipeline: LAT-deep shift register of {v, owner, last}, written on every cycle with v = issue.
  - At tag stage LAT, *_res_valid for the owner = v, *_res_last = last, and *_res_sh = sb_out.
  - The non-owner's res_valid = 0. Results are not back-pressured.
- Latency: a byte accepted in cycle t produces res_valid in cycle t+LAT. Throughput is 1 byte/cycle with no bubbles between bursts other than the IDLE cycle.
- busy = (state != IDLE) || OR of all tag v bits.
- sb_in with no issue: holds the last issued value (default build).
- A requester dropping *_valid mid-burst is a legal stall; grant remains locked.
- Reset mid-burst: FSM goes to IDLE and the tag pipeline clears. In-flight results never produce res_valid, and sb_out is ignored.
- Share values are never combined: each share is routed bit-exact. No XOR across shares anywhere in this block.

Optional Feature:
- Macro SBOX_IDLE_ZERO_EN.
- Defined: on cycles without issue, sb_in = all zeros. This removes cross-byte transitions on idle cycles.
- Undefined: sb_in holds the last issued value; no extra mux.

Decomposition:
- Shared package sbox_sched_pkg: owner encoding (OWN_S = 0, OWN_K = 1), FSM state encoding (IDLE, GRANT_S, GRANT_K), and the tag record width constant (3 bits).
- One natural sub-module, sbox_tag_pipe: a parameterised LAT-deep valid/owner/last shift register with synchronous clear.

Test Plan:
- Single key byte, shares unmasked to 0x53 (0x53, 0, 0, 0), with a real S-box attached -> k_res_valid at t+2, XOR of result shares = 0xED, k_res_last = 1.
- State burst of 16 bytes 0x00..0x0F, rnd_valid = 1 -> s_ready high for 16 consecutive cycles, 16 s_res pulses starting at t+2, XOR of the first result = 0x63, s_res_last on the 16th.
- s_valid and k_valid both raised in IDLE after reset -> key granted first (4 bytes). After one IDLE cycle the state burst is granted; the next contention grants state.
- rnd_valid low for cycles 3-5 of a state burst -> no ready/issue in those cycles, rnd_take = 0, and result pulses show a matching 3-cycle gap.
- RST asserted one cycle after issuing 2 key bytes -> no k_res_valid in the next 4 cycles, busy = 0 and all outputs 0 on the cycle after reset.
- SBOX_IDLE_ZERO_EN defined, idle gap between bursts -> sb_in = 0; undefined -> sb_in equals the last issued shares.
